// File: rtl/bsg_manycore_sdr_reset_sequencer_row.sv
// Sequenced SDR link reset for one row of north/south channels, pipelined hop-by-hop.
// Optional status ports (phase_o, abort_o) under `define BSG_MANYCORE_SDR_RESET_SEQ_STATUS_EN.

module bsg_manycore_sdr_reset_hop #(
  parameter int hop_regs_p = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [4:0] prev,
  output logic [4:0] fwd,
  output logic [4:0] chan
);
  // vector layout: {token, downstream, downlink, uplink, core}
  localparam logic [4:0] rst_vec_lp = 5'b01111;

  if (hop_regs_p == 0) begin : g_comb
    assign fwd = prev;
  end else begin : g_reg
    logic [hop_regs_p-1:0][4:0] pipe;
    always_ff @(posedge clk) begin
      if (reset) pipe <= {hop_regs_p{rst_vec_lp}};
      else begin
        pipe[0] <= prev;
        for (int i = 1; i < hop_regs_p; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign fwd = pipe[hop_regs_p-1];
  end

  // masking only affects this channel; downstream hops still see fwd
  assign chan = en ? fwd : rst_vec_lp;
endmodule

module bsg_manycore_sdr_reset_sequencer_row #(
  parameter int num_tiles_x_p  = 16,
  parameter int hop_regs_p     = 1,
  parameter int phase_cycles_p = 16
) (
  input  logic                     core_clk_i,
  input  logic                     core_reset_i,
  input  logic                     start_i,
  output logic                     ready_o,
  output logic                     done_o,
  input  logic [num_tiles_x_p-1:0] channel_en_i,
  output logic [num_tiles_x_p-1:0] core_reset_ver_o,
  output logic                     core_reset_o,
  output logic [num_tiles_x_p-1:0] async_uplink_reset_o,
  output logic [num_tiles_x_p-1:0] async_downlink_reset_o,
  output logic [num_tiles_x_p-1:0] async_downstream_reset_o,
  output logic [num_tiles_x_p-1:0] async_token_reset_o
`ifdef BSG_MANYCORE_SDR_RESET_SEQ_STATUS_EN
  ,
  output logic [3:0]               phase_o,
  output logic [0:0]               abort_o
`endif
);
  localparam logic [4:0] rst_vec_lp  = 5'b01111;
  localparam int drain_cycles_lp     = num_tiles_x_p * hop_regs_p;
  localparam int pcw_lp              = $clog2(phase_cycles_p + 1);
  localparam int dcw_lp              = (drain_cycles_lp > 0) ? $clog2(drain_cycles_lp + 1) : 1;
  localparam int drain_ld_lp         = (drain_cycles_lp > 0) ? drain_cycles_lp - 1 : 0;

  typedef enum logic [3:0] {
    IDLE = 4'd0, ASSERT = 4'd1, TOKEN_HI = 4'd2, TOKEN_LO = 4'd3, UP_REL = 4'd4,
    DOWN_REL = 4'd5, STREAM_REL = 4'd6, CORE_REL = 4'd7, DRAIN = 4'd8, DONE = 4'd9
  } state_e;

  state_e              state_r, state_n;
  logic [pcw_lp-1:0]   phase_cnt_r;
  logic [dcw_lp-1:0]   drain_cnt_r;
  logic [4:0]          master_r, master_n;
  logic                start_r;
  logic                phase_tc, drain_tc;

  assign ready_o  = (state_r == IDLE) || (state_r == DONE);
  assign done_o   = (state_r == DONE);
  assign phase_tc = (phase_cnt_r == '0);
  assign drain_tc = (drain_cnt_r == '0);

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE:       if (start_r)  state_n = ASSERT;
      ASSERT:     if (phase_tc) state_n = TOKEN_HI;
      TOKEN_HI:   if (phase_tc) state_n = TOKEN_LO;
      TOKEN_LO:   if (phase_tc) state_n = UP_REL;
      UP_REL:     if (phase_tc) state_n = DOWN_REL;
      DOWN_REL:   if (phase_tc) state_n = STREAM_REL;
      STREAM_REL: if (phase_tc) state_n = CORE_REL;
      CORE_REL:   if (phase_tc) state_n = (drain_cycles_lp == 0) ? DONE : DRAIN;
      DRAIN:      if (drain_tc) state_n = DONE;
      DONE:       if (start_r)  state_n = ASSERT;
      default:                  state_n = IDLE;
    endcase
  end

  // master vector tracks the state being entered so it changes on the entry edge
  always_comb begin
    master_n = rst_vec_lp;
    unique case (state_n)
      IDLE, ASSERT, TOKEN_LO: master_n = 5'b01111;
      TOKEN_HI:               master_n = 5'b11111;
      UP_REL:                 master_n = 5'b01101;
      DOWN_REL:               master_n = 5'b01001;
      STREAM_REL:             master_n = 5'b00001;
      default:                master_n = 5'b00000;
    endcase
  end

  always_ff @(posedge core_clk_i) begin
    if (core_reset_i) begin
      state_r     <= IDLE;
      start_r     <= 1'b0;
      master_r    <= rst_vec_lp;
      phase_cnt_r <= '0;
      drain_cnt_r <= '0;
    end else begin
      state_r  <= state_n;
      start_r  <= start_i & ready_o;
      master_r <= master_n;
      if (state_n != state_r) begin
        phase_cnt_r <= pcw_lp'(phase_cycles_p - 1);
        drain_cnt_r <= dcw_lp'(drain_ld_lp);
      end else begin
        if (!phase_tc) phase_cnt_r <= phase_cnt_r - pcw_lp'(1);
        if (!drain_tc) drain_cnt_r <= drain_cnt_r - dcw_lp'(1);
      end
    end
  end

  logic [num_tiles_x_p:0][4:0]   chain;
  logic [num_tiles_x_p-1:0][4:0] chan;
  assign chain[0] = master_r;

  for (genvar x = 0; x < num_tiles_x_p; x++) begin : g_ch
    bsg_manycore_sdr_reset_hop #(.hop_regs_p(hop_regs_p)) u_hop (
      .clk   (core_clk_i),
      .reset (core_reset_i),
      .en    (channel_en_i[x]),
      .prev  (chain[x]),
      .fwd   (chain[x+1]),
      .chan  (chan[x])
    );
    assign core_reset_ver_o[x]         = chan[x][0];
    assign async_uplink_reset_o[x]     = chan[x][1];
    assign async_downlink_reset_o[x]   = chan[x][2];
    assign async_downstream_reset_o[x] = chan[x][3];
    assign async_token_reset_o[x]      = chan[x][4];
  end

  assign core_reset_o = chain[num_tiles_x_p][0];

`ifdef BSG_MANYCORE_SDR_RESET_SEQ_STATUS_EN
  logic abort_r;
  always_ff @(posedge core_clk_i)
    abort_r <= core_reset_i && (state_r != IDLE) && (state_r != DONE);
  assign phase_o = state_r;
  assign abort_o = abort_r;
`endif
endmodule

// File: tb/tb_bsg_manycore_sdr_reset_sequencer_row.sv
// Scoreboard bench: a spec timeline model pushes per-edge expectations, a negedge checker pops them.
module tb_bsg_manycore_sdr_reset_sequencer_row;
  localparam int N = 4;
  localparam int P = 4;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic         rst, start;
  logic [N-1:0] en;

  logic         a_ready, a_done, a_core_o;
  logic [N-1:0] a_core, a_up, a_dn, a_str, a_tok;
  logic         b_ready, b_done, b_core_o;
  logic [N-1:0] b_core, b_up, b_dn, b_str, b_tok;

  bsg_manycore_sdr_reset_sequencer_row #(.num_tiles_x_p(N), .hop_regs_p(1), .phase_cycles_p(P)) u_dut (
    .core_clk_i(gclk), .core_reset_i(rst), .start_i(start), .ready_o(a_ready), .done_o(a_done),
    .channel_en_i(en), .core_reset_ver_o(a_core), .core_reset_o(a_core_o),
    .async_uplink_reset_o(a_up), .async_downlink_reset_o(a_dn),
    .async_downstream_reset_o(a_str), .async_token_reset_o(a_tok));

  bsg_manycore_sdr_reset_sequencer_row #(.num_tiles_x_p(N), .hop_regs_p(0), .phase_cycles_p(P)) u_dut_h0 (
    .core_clk_i(gclk), .core_reset_i(rst), .start_i(start), .ready_o(b_ready), .done_o(b_done),
    .channel_en_i(en), .core_reset_ver_o(b_core), .core_reset_o(b_core_o),
    .async_uplink_reset_o(b_up), .async_downlink_reset_o(b_dn),
    .async_downstream_reset_o(b_str), .async_token_reset_o(b_tok));

  typedef struct {
    int         t;
    int         d;
    int         sel;
    logic [4:0] exp;
  } item_t;

  item_t sb[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc = 0;

  always @(posedge gclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b exp=%b", tag, got, exp);
  endtask

  // {token, downstream, downlink, uplink, core} seen r edges after the start edge
  function automatic logic [4:0] seq_vec(int r, bit prev_final);
    if (r < 1) return prev_final ? 5'b00000 : 5'b01111;
    case ((r - 1) / P)
      0:       return 5'b01111;
      1:       return 5'b11111;
      2:       return 5'b01111;
      3:       return 5'b01101;
      4:       return 5'b01001;
      5:       return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] obs(int d, int sel);
    if (d == 0) begin
      if (sel < N)  return {a_tok[sel], a_str[sel], a_dn[sel], a_up[sel], a_core[sel]};
      if (sel == N) return {4'b0, a_done};
      if (sel == N + 1) return {4'b0, a_ready};
      return {4'b0, a_core_o};
    end
    if (sel < N)  return {b_tok[sel], b_str[sel], b_dn[sel], b_up[sel], b_core[sel]};
    if (sel == N) return {4'b0, b_done};
    if (sel == N + 1) return {4'b0, b_ready};
    return {4'b0, b_core_o};
  endfunction

  task automatic push_run(input int e0, input bit pf, input logic [N-1:0] mask, input int from, input int to);
    item_t      it;
    logic [4:0] v;
    for (int t = from; t <= to; t++) begin
      for (int d = 0; d < 2; d++) begin
        int h  = (d == 0) ? 1 : 0;
        int de = 1 + 7 * P + N * h;
        int rd = t - e0;
        it.t = t;
        it.d = d;
        for (int x = 0; x < N; x++) begin
          it.sel = x;
          it.exp = mask[x] ? seq_vec(t - e0 - (x + 1) * h, pf) : 5'b01111;
          sb.push_back(it);
        end
        it.sel = N;
        it.exp = {4'b0, (rd >= de) || (rd < 1 && pf)};
        sb.push_back(it);
        it.sel = N + 1;
        it.exp = {4'b0, (rd < 1) || (rd >= de)};
        sb.push_back(it);
        v = seq_vec(t - e0 - N * h, pf);
        it.sel = N + 2;
        it.exp = {4'b0, v[0]};
        sb.push_back(it);
      end
    end
  endtask

  always @(negedge gclk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].t == cyc) begin
        chk($sformatf("e%0d dut%0d sel%0d", sb[i].t, sb[i].d, sb[i].sel),
            obs(sb[i].d, sb[i].sel), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge gclk);
    #1;
  endtask

  int e0, e1, e2;

  initial begin
    rst = 1'b1; start = 1'b0; en = '1;
    step(2);
    push_run(100000, 1'b0, '1, cyc + 1, cyc + 5);   // reset and idle state
    step(3);
    rst = 1'b0;
    step(2);

    // full sequence, start held high (ignored) during TOKEN_LO
    e0 = cyc + 1;
    start = 1'b1;
    push_run(e0, 1'b0, '1, e0, e0 + 36);
    step(1); start = 1'b0;
    step(8); start = 1'b1;
    step(4); start = 1'b0;
    step(25);

    // re-sequence from DONE with channel 2 masked
    e1 = cyc + 1;
    en = 4'b1011;
    start = 1'b1;
    push_run(e1, 1'b1, 4'b1011, e1, e1 + 36);
    step(1); start = 1'b0;
    step(37);

    // re-sequence, then reset mid UP_REL
    e2 = cyc + 1;
    en = '1;
    start = 1'b1;
    push_run(e2, 1'b1, '1, e2, e2 + 14);
    step(1); start = 1'b0;
    step(14);
    rst = 1'b1;
    push_run(cyc + 100000, 1'b0, '1, e2 + 15, e2 + 19);
    step(1); rst = 1'b0;
    step(6);

    chk("sb_empty", (sb.size() == 0) ? 5'd0 : 5'd1, 5'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bsg_manycore_sdr_reset_sequencer_row.md
Name: bsg_manycore_sdr_reset_sequencer_row

Overview:
- Generates the full SDR link reset sequence for a row of num_tiles_x_p north/south SDR channels, replacing the pass-through reset daisy chain with a sequenced, pipelined one.
- One FSM drives a master reset vector: core, uplink, downlink, downstream, token.
- The vector travels hop-by-hop through per-channel register stages, so channel x sees it (x+1)*hop_regs_p cycles after the master.
- Supports a per-channel enable mask and a start/done handshake.

Parameters:
- num_tiles_x_p, 16: number of SDR channels in the row; must be ≥1.
- hop_regs_p, 1: register stages per channel hop; 0 means channel x sees the master vector combinationally.
- phase_cycles_p, 16: cycles spent in each sequencing phase; must be ≥1.

Ports:
- core_clk_i  in  1  single clock.
- core_reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  request a reset sequence; accepted only when ready_o=1.
- ready_o  out  1  FSM is in IDLE or DONE and can accept start_i.
- done_o  out  1  sequence complete and every channel has seen the final vector.
- channel_en_i  in  num_tiles_x_p  per-channel enable; 0 forces that channel's resets asserted.
- core_reset_ver_o  out  num_tiles_x_p  per-column core reset feeding the tile column.
- core_reset_o  out  1  core reset at the end of the chain (last channel, unmasked).
- async_uplink_reset_o  out  num_tiles_x_p  per-channel uplink reset.
- async_downlink_reset_o  out  num_tiles_x_p  per-channel downlink reset.
- async_downstream_reset_o  out  num_tiles_x_p  per-channel downstream reset.
- async_token_reset_o  out  num_tiles_x_p  per-channel token reset.

Behaviour:
- Reset values (core_reset_i=1):
  - FSM state = IDLE.
  - Master vector: core, uplink, downlink and downstream = 1; token = 0.
  - All hop registers load the same value.
  - Every per-channel output: core, uplink, downlink, downstream = 1; token = 0.
  - core_reset_o = 1, done_o = 0, ready_o = 1 (first cycle after reset deasserts).
- FSM states and master vector. Each state except IDLE, DRAIN and DONE lasts exactly phase_cycles_p cycles:
  - IDLE: holds the reset vector.
  - ASSERT: core, uplink, downlink, downstream = 1; token = 0.
  - TOKEN_HI: token = 1.
  - TOKEN_LO: token = 0.
  - UP_REL: uplink = 0.
  - DOWN_REL: downlink = 0.
  - STREAM_REL: downstream = 0.
  - CORE_REL: core = 0.
  - DRAIN: lasts num_tiles_x_p*hop_regs_p cycles.
  - DONE: done_o = 1.
- Transitions: IDLE→ASSERT on start_i; then each state advances to the next in the order listed; DONE→ASSERT on start_i (re-sequence).
- Phase timing:
  - Phase counter width is clog2(phase_cycles_p+1). It loads on state entry and advances at terminal count.
  - The master vector is registered. If start_i is sampled at edge 0, ASSERT begins at edge 1 and state k begins at edge 1+k*phase_cycles_p.
- Propagation:
  - hop stage x receives stage x-1's output; stage 0 receives the master.
  - Channel x outputs = hop stage x output AND-masked: if channel_en_i[x]=0, core/uplink/downlink/downstream = 1 and token = 0, combinationally from channel_en_i.
  - Masked channels still forward the unmasked vector downstream.
  - core_reset_ver_o[x] = channel x core bit. core_reset_o = last hop stage core bit, not masked.
- ready_o = 1 in IDLE and DONE only. start_i outside IDLE/DONE is ignored.
- done_o deasserts on the cycle ASSERT is re-entered.
- core_reset_i mid-sequence: on the next edge, the FSM goes to IDLE and all hop registers reload reset values. No partial release survives.
- channel_en_i toggled mid-sequence takes effect immediately on that channel's outputs only.

Optional Feature:
- Macro: BSG_MANYCORE_SDR_RESET_SEQ_STATUS_EN.
- Defined: adds output phase_o [3:0], the current FSM state encoding (IDLE=0 … DONE=9), and output abort_o [0:0], a one-cycle pulse when core_reset_i arrives in any state other than IDLE or DONE.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan (num_tiles_x_p=4, hop_regs_p=1, phase_cycles_p=4 unless stated):
- Reset then start_i at edge 0:
  - master token rises at edge 5 and falls at edge 9.
  - channel 0 token = 1 over edges 6–9; channel 3 token = 1 over edges 9–12.
  - channel 3 uplink falls at edge 17, core_reset_ver_o[3] falls at edge 29, done_o rises at edge 33.
- channel_en_i=4'b1011 through the full sequence:
  - channel 2 stays at core/up/down/stream = 1, token = 0 throughout.
  - channel 3 and core_reset_o release on the same edges as with the all-ones mask.
- core_reset_i pulsed at edge 15 (mid UP_REL): on the next edge, all outputs return to reset values; state IDLE, ready_o = 1, done_o = 0.
- start_i held high during TOKEN_LO: no effect; done_o still rises at edge 33.
- In DONE, assert start_i: done_o drops next edge; master core/up/down/stream reassert; channel 3 sees it 4 cycles later.
- hop_regs_p=0: all four channels change on the same edge as the master; done_o rises at edge 29.
